seq_detector: RTL and testbench
===============================

Name: seq_detector

Overview:
- Parametrised successor to the Lab 0 fixed-pattern serial FSM detector.
- Watches a 1-bit serial stream, qualified by a valid strobe, for a runtime-loadable pattern of 1..PAT_W bits.
- Supports overlapping and non-overlapping detection.
- Emits a registered one-cycle match pulse. Sits between a serial source and downstream control logic.

Parameters:
- PAT_W, 8: maximum pattern length in bits (>=2).
- LEN_W, $clog2(PAT_W+1): width of the length field (derived; do not override).
- CNT_W, 8: width of the match counter (optional feature only).

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- load  in  1  capture pat_in/len_in this cycle.
- pat_in  in  PAT_W  pattern; bit len-1 is the first bit received, bit 0 the last.
- len_in  in  LEN_W  pattern length.
- overlap  in  1  1 = overlapping detection; 0 = restart after each match.
- valid  in  1  In is meaningful this cycle.
- In  in  1  serial data bit.
- Out  out  1  registered match pulse.
- configured  out  1  a legal pattern is loaded.
- match_cnt  out  CNT_W  saturating match count (only when SEQ_DET_CNT_EN is defined).

Behaviour:
- Reset: on a rising edge with reset=1, all registers clear.
  - Out=0, configured=0, match_cnt=0.
  - hist, fill, pattern and length clear.
  - State = UNCONFIG.
  - Reset wins over every other input, including mid-stream and mid-load.
- States:
  - UNCONFIG: Out is forced to 0 and input bits are ignored.
  - RUN: detection is active.
- Load (highest priority after reset):
  - Legal length: len_in in 1..PAT_W.
    - Latch pat_in and len_in; clear hist and fill.
    - Enter RUN; configured=1 from the next cycle.
  - len_in = 0: enter UNCONFIG, configured=0.
  - len_in > PAT_W: clamp to PAT_W.
  - Any In bit offered on a load cycle is discarded. Out=0 on the cycle after a load.
- Shift in RUN (valid=1, load=0):
  - hist_next = {hist[PAT_W-2:0], In}.
  - fill_next = min(fill+1, PAT_W).
- Match condition: fill_next >= len and hist_next[len-1:0] == pat[len-1:0].
- Latency: Out=1 for exactly one cycle, the cycle after the edge that sampled the final pattern bit.
- After a match:
  - overlap=1: fill keeps saturating, so back-to-back matches are possible (e.g. len=1, pattern 1, stream 1,1 gives two consecutive pulses).
  - overlap=0: fill_next is forced to 0, so the next match needs len fresh bits.
- valid=0: hist, fill and count hold; Out goes to 0 next cycle. Bubbles do not break a partial match.
- overlap is sampled each valid cycle. Changing it mid-stream takes effect at the next match.
- Bit ordering is MSB-first: pat_in[len-1] is matched against the earliest bit.

Optional Feature:
- Macro: SEQ_DET_CNT_EN.
- Defined:
  - match_cnt port exists.
  - Increments on each cycle Out is set, saturating at 2^CNT_W-1.
  - Cleared by reset and by load.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package seq_det_pkg holds:
  - state enum (UNCONFIG, RUN);
  - default PAT_W/CNT_W localparams;
  - a len-clamp function.
- Natural sub-module: seq_det_window.
  - Contains the history shift register, fill counter and masked compare.
  - Outputs a combinational hit_next.
  - The top owns the FSM, load logic, the Out register and the counter.

Test Plan:
- Reset: hold reset=1 for 2 cycles mid-stream, after a partial match -> Out=0, configured=0, match_cnt=0; the stream afterwards is ignored until a load.
- Overlapping: load pat=4'b1101, len=4, overlap=1, then stream 1,1,0,1,1,0,1 -> Out pulses after the 4th and 7th bits; match_cnt=2.
- Non-overlapping: same stream and pattern, overlap=0 -> a single pulse after the 4th bit; match_cnt=1.
- Valid bubbles: pattern 101, len=3, stream 1,(valid=0 for 3 cycles),0,1 -> one pulse, one cycle after the final 1; no pulse during the bubbles.
- Load edge cases:
  - len_in=0 -> configured=0, no pulses on any stream.
  - len_in=15 with PAT_W=8 -> length clamped to 8; pattern 8'hA5 matched after 8 bits.
  - load with valid=1 -> that In bit is discarded.
- Saturation: CNT_W=2, len=1, pattern 1, eight consecutive 1s with overlap=1 -> eight pulses; match_cnt stops at 3.

Source files
------------

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared types, default sizes and helpers for the serial
// pattern detector (seq_detector and its sub-modules).
// Contents:
//   state_t     - detector FSM states (UNCONFIG, RUN)
//   DEF_PAT_W   - default maximum pattern length in bits
//   DEF_CNT_W   - default match-counter width (SEQ_DET_CNT_EN builds)
//   clamp_len() - limits a requested pattern length to the supported maximum
package seq_det_pkg;

  typedef enum logic {
    UNCONFIG = 1'b0,
    RUN      = 1'b1
  } state_t;

  localparam int unsigned DEF_PAT_W = 8;
  localparam int unsigned DEF_CNT_W = 8;

  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/seq_detector_if.sv
// seq_detector_if: configuration/stream/result bundle of seq_detector.
// Optional macro: SEQ_DET_CNT_EN adds the match_cnt signal.
// Signals:
//   load       capture pat_in/len_in this cycle
//   pat_in     [PAT_W] pattern, bit len-1 is the earliest bit
//   len_in     [LEN_W] pattern length (0 = unconfigure, >PAT_W clamps)
//   overlap    1 = overlapping detection, 0 = restart after a match
//   valid      In is meaningful this cycle
//   In         serial data bit
//   Out        registered one-cycle match pulse
//   configured a legal pattern is loaded
//   match_cnt  [CNT_W] saturating match count (SEQ_DET_CNT_EN only)
// Modports: master = stream source/controller, slave = detector.
interface seq_detector_if
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = DEF_PAT_W,
  parameter int unsigned CNT_W = DEF_CNT_W
) ();

  localparam int unsigned LEN_W = $clog2(PAT_W + 1);

  if (PAT_W < 2 || CNT_W < 1) begin : g_bad_param
    $error("seq_detector_if: PAT_W must be >= 2 and CNT_W >= 1");
  end

  logic             load;
  logic [PAT_W-1:0] pat_in;
  logic [LEN_W-1:0] len_in;
  logic             overlap;
  logic             valid;
  logic             In;
  logic             Out;
  logic             configured;
`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] match_cnt;
`endif

  modport master (
    output load, pat_in, len_in, overlap, valid, In,
    input  Out, configured
`ifdef SEQ_DET_CNT_EN
    , input match_cnt
`endif
  );

  modport slave (
    input  load, pat_in, len_in, overlap, valid, In,
    output Out, configured
`ifdef SEQ_DET_CNT_EN
    , output match_cnt
`endif
  );

endinterface

// File: rtl/seq_det_window.sv
// seq_det_window: history shift register, fill counter and masked pattern
// compare for seq_detector.
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   i_clear       clear history and fill (pattern load)
//   i_shift       accept i_bit this cycle
//   i_bit         serial data bit
//   i_overlap     1 = keep fill after a hit, 0 = restart fill
//   i_pat, i_len  active pattern and length (1..PAT_W)
//   o_hit_next    combinational: the bit being shifted now completes a match
module seq_det_window
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = DEF_PAT_W,
  localparam int unsigned LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_shift,
  input  logic             i_bit,
  input  logic             i_overlap,
  input  logic [PAT_W-1:0] i_pat,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_hit_next
);

  logic [PAT_W-1:0] r_hist;
  logic [PAT_W-1:0] w_hist_next;
  logic [PAT_W-1:0] w_mask;
  logic [LEN_W-1:0] r_fill;
  logic [LEN_W-1:0] w_fill_inc;
  logic [LEN_W-1:0] w_fill_next;
  logic             w_hit;

  always_comb begin
    w_hist_next = {r_hist[PAT_W-2:0], i_bit};
    // Saturate explicitly: PAT_W may equal 2**LEN_W-1, so +1 could wrap.
    w_fill_inc  = (r_fill == LEN_W'(PAT_W)) ? r_fill : r_fill + 1'b1;
    w_mask      = '0;
    for (int unsigned k = 0; k < PAT_W; k++) begin
      w_mask[k] = (k < 32'(i_len));
    end
    w_hit       = (w_fill_inc >= i_len) &&
                  (((w_hist_next ^ i_pat) & w_mask) == '0);
    // Non-overlapping mode needs len fresh bits before the next match.
    w_fill_next = (w_hit && !i_overlap) ? '0 : w_fill_inc;
  end

  assign o_hit_next = i_shift && w_hit;

  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_shift) begin
      r_hist <= w_hist_next;
      r_fill <= w_fill_next;
    end
  end

endmodule

// File: rtl/seq_detector.sv
// seq_detector: runtime-loadable serial pattern detector (1..PAT_W bits,
// MSB-first), overlapping or restart-after-match, registered match pulse.
// Optional macro: SEQ_DET_CNT_EN adds a saturating match counter.
// Ports:
//   clock  system clock, all state on rising edge
//   reset  synchronous active-high reset, wins over everything
//   bus    seq_detector_if.slave (load/pattern/stream in, Out/configured/
//          match_cnt out)
module seq_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = DEF_PAT_W,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input logic           clock,
  input logic           reset,
  seq_detector_if.slave bus
);

  localparam int unsigned LEN_W = $clog2(PAT_W + 1);

  if (PAT_W < 2 || CNT_W < 1) begin : g_bad_param
    $error("seq_detector: PAT_W must be >= 2 and CNT_W >= 1");
  end

  state_t           r_state;
  state_t           w_state_next;
  logic [PAT_W-1:0] r_pat;
  logic [PAT_W-1:0] w_pat_next;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] w_len_next;
  logic [LEN_W-1:0] w_len_clamped;
  logic             r_out;
  logic             w_out_next;
  logic             w_shift;
  logic             w_hit_next;

  assign w_len_clamped = LEN_W'(clamp_len(32'(bus.len_in), PAT_W));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= UNCONFIG;
      r_pat   <= '0;
      r_len   <= '0;
      r_out   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pat   <= w_pat_next;
      r_len   <= w_len_next;
      r_out   <= w_out_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pat_next   = r_pat;
    w_len_next   = r_len;
    w_out_next   = 1'b0;
    w_shift      = 1'b0;
    if (bus.load) begin
      w_pat_next   = bus.pat_in;
      w_len_next   = w_len_clamped;
      w_state_next = (w_len_clamped == '0) ? UNCONFIG : RUN;
    end else begin
      unique case (r_state)
        UNCONFIG: ;
        RUN: begin
          w_shift    = bus.valid;
          w_out_next = w_hit_next;
        end
        default: w_state_next = UNCONFIG;
      endcase
    end
  end

  seq_det_window #(
    .PAT_W(PAT_W)
  ) u_window (
    .clock     (clock),
    .reset     (reset),
    .i_clear   (bus.load),
    .i_shift   (w_shift),
    .i_bit     (bus.In),
    .i_overlap (bus.overlap),
    .i_pat     (r_pat),
    .i_len     (r_len),
    .o_hit_next(w_hit_next)
  );

  assign bus.Out        = r_out;
  assign bus.configured = (r_state == RUN);

`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (reset || bus.load) begin
      r_cnt <= '0;
    end else if (w_out_next && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.match_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_seq_detector.sv
// tb_seq_detector: self-checking bench for seq_detector. A queue-based
// reference model predicts Out/configured/match_cnt for every driven cycle;
// per-scenario pulse counts are also checked against fixed values.
module tb_seq_detector;

  localparam int unsigned PAT_W = 8;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned LEN_W = $clog2(PAT_W + 1);

  typedef struct packed {
    logic             out;
    logic             cfg;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_detector_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

  seq_detector #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  exp_t sb[$];
  int n_err   = 0;
  int n_chk   = 0;
  int n_pulse = 0;

  logic             m_cfg;
  logic [PAT_W-1:0] m_pat;
  int unsigned      m_len;
  bit               m_q[$];
  logic [CNT_W-1:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_match();
    int unsigned sz;
    sz = m_q.size();
    if (m_len == 0 || sz < m_len) return 1'b0;
    for (int unsigned k = 0; k < m_len; k++) begin
      if (m_q[sz - m_len + k] != m_pat[m_len - 1 - k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic cyc(input logic r, input logic ld, input logic [PAT_W-1:0] p,
                     input logic [LEN_W-1:0] l, input logic ov, input logic vl,
                     input logic b);
    exp_t e;
    exp_t g;
    @(negedge clk);
    rst         = r;
    bus.load    = ld;
    bus.pat_in  = p;
    bus.len_in  = l;
    bus.overlap = ov;
    bus.valid   = vl;
    bus.In      = b;
    e.out = 1'b0;
    if (r) begin
      m_cfg = 1'b0; m_pat = '0; m_len = 0; m_q.delete(); m_cnt = '0;
    end else if (ld) begin
      m_len = (32'(l) > PAT_W) ? PAT_W : 32'(l);
      m_cfg = (m_len != 0);
      m_pat = p;
      m_q.delete();
      m_cnt = '0;
    end else if (m_cfg && vl) begin
      m_q.push_back(b);
      if (m_q.size() > PAT_W) void'(m_q.pop_front());
      if (model_match()) begin
        e.out = 1'b1;
        if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
        if (!ov) m_q.delete();
      end
    end
    e.cfg = m_cfg;
    e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      g = sb.pop_front();
      chk("out", 32'(bus.Out), 32'(g.out));
      chk("configured", 32'(bus.configured), 32'(g.cfg));
`ifdef SEQ_DET_CNT_EN
      chk("match_cnt", 32'(bus.match_cnt), 32'(g.cnt));
`endif
    end
    if (bus.Out === 1'b1) n_pulse++;
  endtask

  task automatic load_pat(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l,
                          input logic ov);
    cyc(1'b0, 1'b1, p, l, ov, 1'b0, 1'b0);
  endtask

  task automatic feed_str(input string s, input logic ov);
    for (int i = 0; i < s.len(); i++) begin
      cyc(1'b0, 1'b0, '0, '0, ov, 1'b1, s[i] == "1");
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.load = 1'b0; bus.pat_in = '0; bus.len_in = '0;
    bus.overlap = 1'b0; bus.valid = 1'b0; bus.In = 1'b0;

    // reset state
    cyc(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("rst_cfg", 32'(bus.configured), 32'd0);

    // overlapping
    load_pat(8'b1101, 4'd4, 1'b1);
    n_pulse = 0;
    feed_str("1101101", 1'b1);
    chk("ovl_pulses", n_pulse, 2);
`ifdef SEQ_DET_CNT_EN
    chk("ovl_cnt", 32'(bus.match_cnt), 32'd2);
`endif

    // non-overlapping
    load_pat(8'b1101, 4'd4, 1'b0);
    n_pulse = 0;
    feed_str("1101101", 1'b0);
    chk("novl_pulses", n_pulse, 1);
`ifdef SEQ_DET_CNT_EN
    chk("novl_cnt", 32'(bus.match_cnt), 32'd1);
`endif

    // valid bubbles inside a partial match
    load_pat(8'b101, 4'd3, 1'b1);
    n_pulse = 0;
    feed_str("1", 1'b1);
    cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    chk("bubble_no_pulse", n_pulse, 0);
    feed_str("01", 1'b1);
    chk("bubble_pulses", n_pulse, 1);

    // len_in = 0 unconfigures
    load_pat(8'hFF, 4'd0, 1'b1);
    n_pulse = 0;
    feed_str("11111111", 1'b1);
    chk("len0_pulses", n_pulse, 0);
    chk("len0_cfg", 32'(bus.configured), 32'd0);

    // len_in > PAT_W clamps to PAT_W
    load_pat(8'hA5, 4'd15, 1'b1);
    n_pulse = 0;
    feed_str("1010010", 1'b1);
    chk("clamp_early", n_pulse, 0);
    feed_str("1", 1'b1);
    chk("clamp_pulses", n_pulse, 1);

    // bit offered on the load cycle is discarded
    cyc(1'b0, 1'b1, 8'b11, 4'd2, 1'b1, 1'b1, 1'b1);
    n_pulse = 0;
    feed_str("1", 1'b1);
    chk("load_discard", n_pulse, 0);
    feed_str("1", 1'b1);
    chk("load_discard_pulse", n_pulse, 1);

    // reset mid-stream after a partial match, second reset cycle also loads
    load_pat(8'b1101, 4'd4, 1'b1);
    feed_str("110", 1'b1);
    cyc(1'b1, 1'b0, '0, '0, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 8'b1101, 4'd4, 1'b1, 1'b1, 1'b1);
    n_pulse = 0;
    feed_str("1101101", 1'b1);
    chk("rst_pulses", n_pulse, 0);
    chk("rst_cfg2", 32'(bus.configured), 32'd0);

    // counter saturation
    load_pat(8'b1, 4'd1, 1'b1);
    n_pulse = 0;
    feed_str("11111111", 1'b1);
    chk("sat_pulses", n_pulse, 8);
`ifdef SEQ_DET_CNT_EN
    chk("sat_cnt", 32'(bus.match_cnt), 32'd3);
`endif

    cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
